// File: rtl/mod3_stream_scheduler.sv
// Arbitrated word-level front end for a serial mod-3 residue datapath.
// Optional feature: define MOD3_SCHED_RR_EN for round-robin arbitration (fixed priority otherwise).
module mod3_stream_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     data,
  output logic [NREQ-1:0]           ack,
  output logic                      busy,
  output logic                      ser_bit,
  output logic [1:0]                residue,
  output logic                      done,
  output logic                      div3,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Residue update for one incoming bit: (2*r + b) mod 3 on a 2-bit state.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  logic [0:0]       state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic [1:0]       residue_r;
  logic [NREQ-1:0]  ack_r;
  logic             busy_r;
  logic             ser_bit_r;
  logic             done_r;
  logic             div3_r;
  logic [GW-1:0]    grant_r;

  logic             any_req_s;
  logic [GW-1:0]    win_s;
  logic [WIDTH-1:0] word_s;
  logic [1:0]       res_next_s;
  logic             last_s;

  assign any_req_s  = |req;
  assign res_next_s = mod3_step(residue_r, shift_r[WIDTH-1]);
  assign last_s     = (cnt_r == CW'(WIDTH - 1));

`ifdef MOD3_SCHED_RR_EN
  logic [GW-1:0] ptr_r;
  logic [GW-1:0] idx_s;
  logic          found_s;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = ptr_r;
    for (int k = 1; k <= NREQ; k++) begin
      if (int'(ptr_r) + k >= NREQ) begin
        idx_s = GW'(int'(ptr_r) + k - NREQ);
      end else begin
        idx_s = GW'(int'(ptr_r) + k);
      end
      if (req[idx_s] && !found_s) begin
        win_s   = idx_s;
        found_s = 1'b1;
      end else begin
        win_s   = win_s;
      end
    end
  end

  // Pointer remembers the most recent winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= GW'(NREQ - 1);
    end else if (state_r == IDLE && any_req_s) begin
      ptr_r <= win_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    win_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_s = GW'(i);
      end else begin
        win_s = win_s;
      end
    end
  end
`endif

  // Select the winning requester's word.
  always_comb begin
    word_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_s == GW'(i)) begin
        word_s = data[i*WIDTH +: WIDTH];
      end else begin
        word_s = word_s;
      end
    end
  end

  // Grant/shift sequencer; ser_bit is pre-loaded so it tracks the current MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      cnt_r     <= '0;
      residue_r <= 2'd0;
      ack_r     <= '0;
      busy_r    <= 1'b0;
      ser_bit_r <= 1'b0;
      done_r    <= 1'b0;
      div3_r    <= 1'b0;
      grant_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (any_req_s) begin
            state_r   <= SHIFT;
            shift_r   <= word_s;
            cnt_r     <= '0;
            residue_r <= 2'd0;
            ack_r     <= NREQ'(1) << win_s;
            grant_r   <= win_s;
            busy_r    <= 1'b1;
            ser_bit_r <= word_s[WIDTH-1];
          end else begin
            ack_r     <= '0;
            busy_r    <= 1'b0;
            ser_bit_r <= 1'b0;
          end
        end
        SHIFT: begin
          ack_r     <= '0;
          residue_r <= res_next_s;
          shift_r   <= {shift_r[WIDTH-2:0], 1'b0};
          cnt_r     <= cnt_r + CW'(1);
          if (last_s) begin
            state_r   <= IDLE;
            done_r    <= 1'b1;
            div3_r    <= (res_next_s == 2'd0);
            busy_r    <= 1'b0;
            ser_bit_r <= 1'b0;
          end else begin
            done_r    <= 1'b0;
            ser_bit_r <= shift_r[WIDTH-2];
          end
        end
        default: begin
          state_r   <= IDLE;
          ack_r     <= '0;
          busy_r    <= 1'b0;
          ser_bit_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_r;
  assign busy     = busy_r;
  assign ser_bit  = ser_bit_r;
  assign residue  = residue_r;
  assign done     = done_r;
  assign div3     = div3_r;
  assign grant_id = grant_r;

endmodule
